// File: rtl/shift_nib_in_pout_param.sv
// rtl/shift_nib_in_pout_param.sv - nibble-in shift register with latched, tri-stated parallel output
module shift_nib_in_pout_param #(
    parameter  int NIB_W     = 4,
    parameter  int NIBBLES   = 2,
    parameter  int MSB_FIRST = 1,
    localparam int OUT_W     = NIB_W * NIBBLES,
    localparam int CNT_W     = $clog2(NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             select,
    input  logic             le,
    input  logic [0:NIB_W-1] din,
    output wire  [0:OUT_W-1] dout,
    output logic [0:OUT_W-1] dout_int,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             overrun,
    output logic             valid
);

    logic [0:OUT_W-1] sreg;
    logic [0:OUT_W-1] latch;
    logic [0:OUT_W-1] sreg_shift;

    // Bit 0 is the MS position; the newest nibble enters at the end selected by MSB_FIRST.
    generate
        if (NIBBLES == 1) begin : g_single
            assign sreg_shift = din;
        end else if (MSB_FIRST != 0) begin : g_msb_first
            assign sreg_shift = {sreg[NIB_W:OUT_W-1], din};
        end else begin : g_lsb_first
            assign sreg_shift = {din, sreg[0:OUT_W-NIB_W-1]};
        end
    endgenerate

    assign full = (cnt == CNT_W'(NIBBLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            latch   <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
            valid   <= 1'b0;
        end else if (!select) begin
            valid <= 1'b0;
        end else if (le) begin
            latch   <= sreg;
            cnt     <= '0;
            overrun <= 1'b0;
            valid   <= 1'b1;
        end else begin
            // A shift while full still happens; the oldest nibble is dropped.
            sreg  <= sreg_shift;
            valid <= 1'b0;
            if (full) begin
                overrun <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout_int = latch;
    assign dout     = select ? latch : {OUT_W{1'bz}};

endmodule
